// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one 24-bit I2C transfer engine between NUM_REQ
// command sources. Round-robin arbitration, GO/END/ACK handshake with NACK
// retries, a per-wait-state timeout and a forced bus-free gap between
// transfers. Each grant is closed by exactly one done or error pulse.
`timescale 1ns/1ps

module i2c_cmd_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int GAP_CYC     = 5000
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [NUM_REQ-1:0]     iREQ,
    input  logic [24*NUM_REQ-1:0]  iREQ_DATA,
    output logic [NUM_REQ-1:0]     oGNT,
    output logic [NUM_REQ-1:0]     oDONE,
    output logic [NUM_REQ-1:0]     oERR,
    output logic                   oBUSY,
    output logic [23:0]            oI2C_DATA,
    output logic                   oI2C_GO,
    input  logic                   iI2C_END,
    input  logic                   iI2C_ACK
);

    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = IW + 1;
    localparam int TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ARB        = 4'd1;
    localparam logic [3:0] S_LAUNCH     = 4'd2;
    localparam logic [3:0] S_WAIT_START = 4'd3;
    localparam logic [3:0] S_WAIT_END   = 4'd4;
    localparam logic [3:0] S_CHECK      = 4'd5;
    localparam logic [3:0] S_GAP_RETRY  = 4'd6;
    localparam logic [3:0] S_FAIL       = 4'd7;
    localparam logic [3:0] S_GAP        = 4'd8;

    logic [3:0]          r_state;
    logic [TW-1:0]       r_timer;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_idx;
    logic [3:0]          r_retry;
    logic                r_end_m, r_end_s;
    logic                r_ack_m, r_ack_s;
    logic                r_ack_lat;
    logic                r_go;
    logic                r_busy;
    logic [23:0]         r_data;
    logic [NUM_REQ-1:0]  r_gnt, r_done, r_err;

    logic [3:0]          w_state_nx;
    logic                w_found;
    logic [IW-1:0]       w_pick;
    logic [CW-1:0]       w_cand;
    logic [23:0]         w_pick_data;
    logic [NUM_REQ-1:0]  w_pick_oh;

    assign oGNT      = r_gnt;
    assign oDONE     = r_done;
    assign oERR      = r_err;
    assign oBUSY     = r_busy;
    assign oI2C_DATA = r_data;
    assign oI2C_GO   = r_go;

    // Bring the controller's END/ACK flags (slower clock domain) into iCLK.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_end_m <= 1'b1;
            r_end_s <= 1'b1;
            r_ack_m <= 1'b0;
            r_ack_s <= 1'b0;
        end else begin
            r_end_m <= iI2C_END;
            r_end_s <= r_end_m;
            r_ack_m <= iI2C_ACK;
            r_ack_s <= r_ack_m;
        end
    end

    // Circular scan from the slot after the last winner; first requester found wins.
    always_comb begin
        w_found     = 1'b0;
        w_pick      = '0;
        w_cand      = '0;
        w_pick_data = 24'h00_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand  = {1'b0, r_ptr} + CW'(i + 1);
            w_cand  = (w_cand >= CW'(NUM_REQ)) ? (w_cand - CW'(NUM_REQ)) : w_cand;
            w_pick  = (!w_found && iREQ[w_cand[IW-1:0]]) ? w_cand[IW-1:0] : w_pick;
            w_found = w_found | iREQ[w_cand[IW-1:0]];
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pick_data = (w_pick == IW'(k)) ? iREQ_DATA[24*k +: 24] : w_pick_data;
        end
        w_pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
    end

    // Next-state decode for the transfer sequencer.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (|iREQ) w_state_nx = S_ARB;
                else       w_state_nx = S_IDLE;
            end
            S_ARB: begin
                if (w_found) w_state_nx = S_LAUNCH;
                else         w_state_nx = S_IDLE;
            end
            S_LAUNCH: w_state_nx = S_WAIT_START;
            S_WAIT_START: begin
                if (!r_end_s)               w_state_nx = S_WAIT_END;
                else if (r_timer == TO_LAST) w_state_nx = S_FAIL;
                else                        w_state_nx = S_WAIT_START;
            end
            S_WAIT_END: begin
                if (r_end_s)                w_state_nx = S_CHECK;
                else if (r_timer == TO_LAST) w_state_nx = S_FAIL;
                else                        w_state_nx = S_WAIT_END;
            end
            S_CHECK: begin
                if (!r_ack_lat)              w_state_nx = S_GAP;
                else if (r_retry < RETRY_MAX) w_state_nx = S_GAP_RETRY;
                else                         w_state_nx = S_FAIL;
            end
            S_GAP_RETRY: begin
                if (r_timer == GAP_LAST) w_state_nx = S_LAUNCH;
                else                     w_state_nx = S_GAP_RETRY;
            end
            S_FAIL: w_state_nx = S_GAP;
            S_GAP: begin
                if (r_timer == GAP_LAST) w_state_nx = S_IDLE;
                else                     w_state_nx = S_GAP;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register and the shared wait timer (cleared on entry, saturating).
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_state_nx != r_state) r_timer <= '0;
            else if (r_timer != '1)    r_timer <= r_timer + TW'(1);
        end
    end

    // Command capture, GO handshake, retry count and completion pulses.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_ptr     <= IW'(NUM_REQ - 1);
            r_idx     <= '0;
            r_retry   <= 4'd0;
            r_ack_lat <= 1'b0;
            r_go      <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= 24'h00_0000;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            r_err  <= '0;
            r_busy <= (w_state_nx != S_IDLE);
            case (r_state)
                S_ARB: begin
                    if (w_found) begin
                        r_data  <= w_pick_data;
                        r_idx   <= w_pick;
                        r_ptr   <= w_pick;
                        r_gnt   <= w_pick_oh;
                        r_retry <= 4'd0;
                    end
                end
                S_LAUNCH: r_go <= 1'b1;
                S_WAIT_END: begin
                    if (r_end_s) begin
                        r_ack_lat <= r_ack_s;
                        r_go      <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (!r_ack_lat)              r_done[r_idx] <= 1'b1;
                    else if (r_retry < RETRY_MAX) r_retry <= r_retry + 4'd1;
                end
                S_FAIL: begin
                    r_go         <= 1'b0;
                    r_err[r_idx] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter: directed scenarios push expected
// grant/done/error events and expected GO payloads; a monitor and a
// behavioural controller model pop and compare as the DUT produces them.
`timescale 1ns/1ps

module tb_i2c_cmd_arbiter;

    localparam int NREQ = 2;
    localparam int MAXR = 3;
    localparam int TOUT = 300;
    localparam int GAP  = 20;

    localparam logic [1:0] K_GNT  = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    typedef struct {
        logic [1:0]      kind;
        logic [NREQ-1:0] vec;
        logic [23:0]     data;
    } ev_t;

    logic                iCLK = 1'b0;
    logic                iRST = 1'b1;
    logic [NREQ-1:0]     iREQ = '0;
    logic [24*NREQ-1:0]  iREQ_DATA = '0;
    logic [NREQ-1:0]     oGNT, oDONE, oERR;
    logic                oBUSY, oI2C_GO;
    logic [23:0]         oI2C_DATA;
    logic                m_end = 1'b1;
    logic                m_ack = 1'b0;
    logic                m_abort = 1'b0;

    ev_t         exp_q[$];
    logic [23:0] exp_go[$];
    logic        ack_plan[$];
    int          issued[NREQ];
    int          compl[NREQ];
    int          m_run = 10;
    int          n_cmp = 0;
    int          n_bad = 0;

    i2c_cmd_arbiter #(
        .NUM_REQ(NREQ), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TOUT), .GAP_CYC(GAP)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iREQ_DATA(iREQ_DATA),
        .oGNT(oGNT), .oDONE(oDONE), .oERR(oERR), .oBUSY(oBUSY),
        .oI2C_DATA(oI2C_DATA), .oI2C_GO(oI2C_GO),
        .iI2C_END(m_end), .iI2C_ACK(m_ack)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [NREQ-1:0] oh(input int k);
        logic [NREQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic push_ev(input logic [1:0] kind, input int k, input logic [23:0] d);
        ev_t e;
        e.kind = kind;
        e.vec  = oh(k);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_ev(input string name, input logic [1:0] kind, input logic [NREQ-1:0] vec);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s unexpected: got vec %b, expected no event", name, vec);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.vec !== vec || (kind == K_GNT && e.data !== oI2C_DATA)) begin
                n_bad++;
                $display("FAIL %s: got kind %0d vec %b data %h, expected kind %0d vec %b data %h",
                         name, kind, vec, oI2C_DATA, e.kind, e.vec, e.data);
            end
        end
    endtask

    // Monitor: every grant/done/error pulse is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge iCLK);
            if (!iRST) begin
                if (oGNT != '0) check_ev("gnt", K_GNT, oGNT);
                if (oDONE != '0) check_ev("done", K_DONE, oDONE);
                if (oERR != '0) begin
                    check_ev("err", K_ERR, oERR);
                    chk("go_low_at_err", 32'(oI2C_GO), 32'd0);
                end
                for (int k = 0; k < NREQ; k++) begin
                    if (oDONE[k] || oERR[k]) compl[k]++;
                end
            end
        end
    end

    // Requesters hold their level until every issued command is completed.
    initial begin
        forever begin
            @(posedge iCLK);
            #2;
            for (int k = 0; k < NREQ; k++) iREQ[k] = (issued[k] != compl[k]);
        end
    end

    // Controller model: accepts GO, runs m_run cycles, answers from ack_plan.
    initial begin
        forever begin
            @(posedge iCLK);
            #1;
            if (oI2C_GO && !iRST) begin
                n_cmp++;
                if (exp_go.size() == 0) begin
                    n_bad++;
                    $display("FAIL go_attempt unexpected: data %h, expected no attempt", oI2C_DATA);
                end else begin
                    logic [23:0] d;
                    d = exp_go.pop_front();
                    if (d !== oI2C_DATA) begin
                        n_bad++;
                        $display("FAIL go_data: got %h expected %h", oI2C_DATA, d);
                    end
                end
                m_end   = 1'b0;
                m_abort = 1'b0;
                for (int c = 0; c < m_run; c++) begin
                    @(posedge iCLK);
                    #1;
                    if (!oI2C_GO) begin
                        m_abort = 1'b1;
                        break;
                    end
                end
                if (!m_abort) begin
                    m_ack = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b0;
                    m_end = 1'b1;
                    for (int c = 0; c < 64 && oI2C_GO; c++) begin
                        @(posedge iCLK);
                        #1;
                    end
                end else begin
                    m_end = 1'b1;
                end
            end
        end
    end

    task automatic wait_quiet(input string name, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(negedge iCLK);
            if (exp_q.size() == 0 && exp_go.size() == 0 && !oBUSY && iREQ == '0) break;
        end
        n_cmp++;
        if (c >= budget) begin
            n_bad++;
            $display("FAIL %s timeout: events left %0d, attempts left %0d, busy %0b",
                     name, exp_q.size(), exp_go.size(), oBUSY);
        end
    endtask

    task automatic pulse_reset();
        @(negedge iCLK);
        iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int go_cyc;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_go", 32'(oI2C_GO), 32'd0);
        chk("rst_data", 32'(oI2C_DATA), 32'd0);
        chk("rst_gnt", 32'(oGNT), 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        // 1: single request, ACKed, bus-free gap length
        iREQ_DATA[23:0] = 24'h34_0C00;
        push_ev(K_GNT, 0, 24'h34_0C00);
        push_ev(K_DONE, 0, 24'h0);
        exp_go.push_back(24'h34_0C00);
        issued[0]++;
        for (int c = 0; c < 1000 && !oDONE[0]; c++) @(negedge iCLK);
        chk("t1_done_seen", 32'(oDONE[0]), 32'd1);
        n = 0;
        while (oBUSY && n < 1000) begin
            n++;
            @(negedge iCLK);
        end
        chk("t1_gap_len", 32'(n), 32'(GAP));
        wait_quiet("t1_quiet", 500);

        // 2: round robin, both held
        pulse_reset();
        iREQ_DATA = {24'h34_047F, 24'h34_1201};
        for (int r = 0; r < 2; r++) begin
            push_ev(K_GNT, 0, 24'h34_1201);
            push_ev(K_DONE, 0, 24'h0);
            push_ev(K_GNT, 1, 24'h34_047F);
            push_ev(K_DONE, 1, 24'h0);
            exp_go.push_back(24'h34_1201);
            exp_go.push_back(24'h34_047F);
        end
        issued[0] += 2;
        issued[1] += 2;
        wait_quiet("t2_quiet", 2000);

        // 3: two NACKs then ACK
        iREQ_DATA[23:0] = 24'h34_0A55;
        ack_plan = '{1'b1, 1'b1, 1'b0};
        push_ev(K_GNT, 0, 24'h34_0A55);
        push_ev(K_DONE, 0, 24'h0);
        repeat (3) exp_go.push_back(24'h34_0A55);
        issued[0]++;
        wait_quiet("t3_quiet", 2000);

        // 4: NACK exhaustion, then the other requester is served
        iREQ_DATA = {24'h34_0810, 24'h34_06AA};
        ack_plan = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        push_ev(K_GNT, 0, 24'h34_06AA);
        push_ev(K_ERR, 0, 24'h0);
        push_ev(K_GNT, 1, 24'h34_0810);
        push_ev(K_DONE, 1, 24'h0);
        repeat (4) exp_go.push_back(24'h34_06AA);
        exp_go.push_back(24'h34_0810);
        issued[0]++;
        for (int c = 0; c < 100 && !oGNT[0]; c++) @(negedge iCLK);
        issued[1]++;
        wait_quiet("t4_quiet", 3000);

        // 5: END never returns high -> timeout
        m_run = 4 * TOUT;
        iREQ_DATA[47:24] = 24'h34_FFEE;
        push_ev(K_GNT, 1, 24'h34_FFEE);
        push_ev(K_ERR, 1, 24'h0);
        exp_go.push_back(24'h34_FFEE);
        issued[1]++;
        go_cyc = 0;
        for (int c = 0; c < 4 * TOUT; c++) begin
            @(negedge iCLK);
            if (oI2C_GO) go_cyc++;
            if (oERR[1]) break;
        end
        n_cmp++;
        if (go_cyc < TOUT || go_cyc > TOUT + 15) begin
            n_bad++;
            $display("FAIL t5_go_cycles: got %0d expected %0d..%0d", go_cyc, TOUT, TOUT + 15);
        end
        wait_quiet("t5_quiet", 1000);
        m_run = 40;

        // 6: reset during WAIT_END, pointer restarts at requester 0
        iREQ_DATA = {24'h34_1055, 24'h34_0E01};
        push_ev(K_GNT, 0, 24'h34_0E01);
        exp_go.push_back(24'h34_0E01);
        issued[0]++;
        for (int c = 0; c < 200 && !(oI2C_GO && !m_end); c++) @(negedge iCLK);
        repeat (5) @(negedge iCLK);
        issued[1]++;
        @(negedge iCLK);
        push_ev(K_GNT, 0, 24'h34_0E01);
        push_ev(K_DONE, 0, 24'h0);
        push_ev(K_GNT, 1, 24'h34_1055);
        push_ev(K_DONE, 1, 24'h0);
        exp_go.push_back(24'h34_0E01);
        exp_go.push_back(24'h34_1055);
        chk("t6_go_before_rst", 32'(oI2C_GO), 32'd1);
        iRST = 1'b1;
        #1;
        chk("t6_rst_go", 32'(oI2C_GO), 32'd0);
        chk("t6_rst_busy", 32'(oBUSY), 32'd0);
        chk("t6_rst_data", 32'(oI2C_DATA), 32'd0);
        chk("t6_rst_pulses", 32'({oGNT, oDONE, oERR}), 32'd0);
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        wait_quiet("t6_quiet", 3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
Shares the single board I2C controller (24-bit {slave_addr, sub_addr, data} transfer engine with GO/END/ACK handshake) between NUM_REQ command sources, e.g. the boot-time codec/video config sequencer and the runtime volume/line-gain writer. The block performs round-robin arbitration, launches each transfer, and retries on NACK. A timeout catches a hung bus. Each completion is reported back to its requester as a done or error pulse.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_RETRY, 3, additional attempts after a NACK before reporting error (0..15)
TIMEOUT_CYC, 2500000, iCLK cycles allowed per wait state before abort (50 ms at 50 MHz)
GAP_CYC, 5000, idle iCLK cycles forced between consecutive transfers (bus free time)

Ports:
iCLK  in  1  system clock
iRST  in  1  asynchronous active-high reset
iREQ  in  NUM_REQ  per-requester request level; held high until own oDONE/oERR pulse
iREQ_DATA  in  24*NUM_REQ  requester k command at bits [24k+23:24k]
oGNT  out  NUM_REQ  one-hot 1-cycle pulse: command k captured
oDONE  out  NUM_REQ  1-cycle pulse: transfer k ACKed
oERR  out  NUM_REQ  1-cycle pulse: transfer k failed (retries exhausted or timeout)
oBUSY  out  1  high in any state other than IDLE
oI2C_DATA  out  24  command to controller
oI2C_GO  out  1  controller start
iI2C_END  in  1  controller end flag (low while running, high when idle/finished); from slower clock
iI2C_ACK  in  1  controller ack-fail flag; 0 = all bytes ACKed; valid when END high

Behaviour:
- Reset (async, iRST=1): state IDLE; oGNT, oDONE, oERR, oI2C_GO, oBUSY = 0; oI2C_DATA = 0; RR pointer = NUM_REQ-1, so requester 0 has first priority; retry and timer counters = 0.
- iI2C_END and iI2C_ACK pass through 2-flop synchronizers; every reference below is to the synchronized versions (2-cycle latency).
- States:
  - IDLE: if any iREQ, go ARB.
  - ARB: pick the first asserted index scanning circularly from ptr+1; latch its data into oI2C_DATA; latch its index; pulse oGNT; ptr <= index; retry <= 0; go LAUNCH. If iREQ dropped meanwhile, return IDLE with no pulse.
  - LAUNCH: oI2C_GO <= 1; timer cleared; go WAIT_START.
  - WAIT_START: wait for END=0 (controller accepted), then go WAIT_END. On timer = TIMEOUT_CYC-1, go FAIL.
  - WAIT_END: wait for END=1, then sample ACK, drop oI2C_GO, go CHECK. On timeout, go FAIL.
  - CHECK:
    - ACK=0: pulse oDONE[index], go GAP.
    - ACK=1 and retry < MAX_RETRY: retry+1, go GAP_RETRY.
    - Otherwise: go FAIL.
  - GAP_RETRY: wait GAP_CYC, go LAUNCH with the same data.
  - FAIL: drop oI2C_GO, pulse oERR[index], go GAP.
  - GAP: count GAP_CYC, go IDLE.
- Timer is reset on every state entry and saturates. Width is clog2(max(TIMEOUT_CYC, GAP_CYC)) + 1.
- oI2C_DATA is stable from ARB until the next ARB, and never changes while GO=1.
- Exactly one oDONE or oERR pulse per oGNT, at the same index.
- A requester dropping iREQ after grant does not abort the transfer; the completion pulse is still issued.
- Simultaneous requests: RR guarantees no requester waits more than NUM_REQ-1 transfers.
- A new request arriving during GAP is served next, not earlier.
- Reset mid-transfer: GO drops immediately (async). The controller's own reset recovers the bus.

Test Plan:
1. Single request: iREQ[0]=1, data 24'h34_0C00; controller model ACKs. Expect: oGNT=01; GO high; END low then high; oDONE[0] pulse exactly once; GAP of 5000 cycles; oBUSY low afterwards.
2. Round robin: both requests held continuously, data 24'h34_1201 and 24'h34_047F. Expect grant order 0,1,0,1; oI2C_DATA alternates accordingly.
3. NACK retry: model returns ACK=1 twice, then 0. Expect 3 GO assertions with identical data; single oDONE; no oERR.
4. NACK exhaustion: ACK always 1, MAX_RETRY=3. Expect 4 attempts, then oERR[index] pulse, no oDONE; next requester served.
5. Timeout: model never raises END. After TIMEOUT_CYC cycles in WAIT_END, expect GO=0 and an oERR pulse.
6. Reset mid-transfer: assert iRST during WAIT_END. Expect GO=0 and all outputs 0 immediately; after release, requester 0 wins regardless of prior pointer.
